spo2_ratio_calc: RTL
====================

// Module: spo2_ratio_calc
// PURPOSE
//  Downstream consumer of the Controller's filtered channel outputs (Out_RED, Out_IR, 20 bit each).
//  Per window of WINDOW_LEN samples, tracks per-channel max/min and derives AC = max-min, DC = (max+min)/2.
//  At window end, computes R = (AC_red*DC_ir)/(AC_ir*DC_red) as unsigned Q8.8 with a 16-iteration restoring divider.
//  Its output feeds the SpO2 lookup stage.
// PARAMETERS
//  WINDOW_LEN  1000  samples per window (2 s at 500 Hz); legal range 32..65535
//  DW          20    width of the filtered inputs and the AC/DC outputs
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  enable       in   1   high = acquire and compute; low = abort, return to IDLE
//  sample_en    in   1   one-cycle strobe: filter_red/filter_ir hold a new sample
//  filter_red   in   DW  filtered RED channel, unsigned (Controller Out_RED)
//  filter_ir    in   DW  filtered IR channel, unsigned (Controller Out_IR)
//  ac_red       out  DW  last window RED max-min
//  dc_red       out  DW  last window RED (max+min)>>1
//  ac_ir        out  DW  last window IR max-min
//  dc_ir        out  DW  last window IR (max+min)>>1
//  ratio_q88    out  16  R in unsigned Q8.8 (0x0100 = 1.0)
//  ratio_valid  out  1   one-cycle pulse when ratio_q88/ratio_sat update
//  ratio_sat    out  1   last ratio saturated (denominator 0 or R >= 256)
//  busy         out  1   divider running (state CALC)
// BEHAVIOUR
//  Reset: all outputs 0; sample counter 0; max/min registers 0; FSM = IDLE.
//  Acquisition (runs independently of the divider FSM):
//   - Counts only when enable=1 and sample_en=1; samples with sample_en=0 are ignored.
//   - Count 0: load max=min=sample per channel. Later samples: max/min update on strict >/<.
//   - Count WINDOW_LEN-1 (window end, cycle t): counter wraps to 0; next window starts on the next strobe.
//  Window close, edge t+1:
//   - ac_*/dc_* registered. DC uses a DW+1 bit sum, then >>1 (truncate).
//   - num = ac_red*dc_ir and den = ac_ir*dc_red registered as full 2*DW (40-bit) unsigned products.
//   - FSM IDLE->CALC; busy=1.
//  FSM states:
//   - IDLE: wait for window close.
//   - CALC: 16 cycles (t+2..t+17), one quotient bit per cycle, MSB first, on dividend num<<8.
//     Remainder register is 2*DW+1 bits.
//     Pre-check in the first CALC cycle: if den==0 or num >= (den<<8), result = 0xFFFF and sat=1.
//     The FSM still runs the full 16 cycles, so latency is fixed.
//   - DONE: one cycle (edge t+18) registers ratio_q88 and ratio_sat, pulses ratio_valid, then -> IDLE.
//  Latency: window-end strobe at t -> ratio_valid high in the cycle after edge t+18.
//  Window overlap: a window cannot close while busy, because WINDOW_LEN >= 32 > 18.
//  Simultaneous events: a strobe on the window-close cycle belongs to the new window (count 0 load).
//  enable=0 (any cycle):
//   - counter cleared to 0, FSM -> IDLE, no ratio_valid pulse.
//   - ac/dc/ratio outputs hold their last values.
//   - re-enable starts a fresh full window.
//  rst_n low mid-CALC: immediate async clear; no ratio_valid is produced for that window.
//  All arithmetic unsigned; no wrap on AC, since max >= min by construction.
// TESTING
//  1. WINDOW_LEN=32, RED square 2000/3000, IR square 4000/6000
//     -> ac_red=1000, dc_red=2500, ac_ir=2000, dc_ir=5000; ratio_q88=0x0100, sat=0.
//     ratio_valid exactly 18 cycles after the 32nd strobe.
//  2. RED 1000/1500, IR 4000/6000
//     -> R = 500*5000/(2000*1250) = 1.0 -> 0x0100.
//     Change RED to 1000/1600 -> R = 600*5000/(2000*1300) = 1.1538 -> 0x0127.
//  3. IR held constant 5000
//     -> ac_ir=0, den=0 -> ratio_q88=0xFFFF, ratio_sat=1, ratio_valid still pulses at t+18.
//  4. RED AC 60000, IR AC 100 (num >= den<<8) -> 0xFFFF, sat=1.
//     Next window with R=0.5 -> 0x0080, sat=0.
//  5. Drop enable for 1 cycle at sample 20 of 32 -> no ratio_valid.
//     Next ratio arrives 32 strobes after re-enable, computed only from post-enable samples.
//  6. Assert rst_n low during CALC cycle 8 -> all outputs 0 at once, busy=0.
//     After release, the first ratio_valid comes only after a full new window.

Source files
------------

// File: rtl/spo2_ratio_calc.sv
// SpO2 ratio-of-ratios: per-window AC/DC extraction on RED/IR channels
// and a bit-serial restoring divider producing R in unsigned Q8.8.
module spo2_ratio_calc #(
    parameter int WINDOW_LEN = 1000,
    parameter int DW         = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sample_en,
    input  logic [DW-1:0] filter_red,
    input  logic [DW-1:0] filter_ir,
    output logic [DW-1:0] ac_red,
    output logic [DW-1:0] dc_red,
    output logic [DW-1:0] ac_ir,
    output logic [DW-1:0] dc_ir,
    output logic [15:0]   ratio_q88,
    output logic          ratio_valid,
    output logic          ratio_sat,
    output logic          busy
);

    localparam int          PW   = 2 * DW;
    localparam int          RW   = PW + 1;
    localparam logic [15:0] LAST = 16'(WINDOW_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t next;

    logic [15:0]   cnt;
    logic          last;
    logic          win_close;
    logic [DW-1:0] max_red;
    logic [DW-1:0] min_red;
    logic [DW-1:0] max_ir;
    logic [DW-1:0] min_ir;

    logic [DW-1:0] ac_red_w;
    logic [DW-1:0] dc_red_w;
    logic [DW-1:0] ac_ir_w;
    logic [DW-1:0] dc_ir_w;
    logic [PW-1:0] num_w;
    logic [PW-1:0] den_w;

    logic [PW-1:0] num;
    logic [PW-1:0] den;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_in;
    logic [RW-1:0] trial;
    logic [15:0]   dlo;
    logic [15:0]   quot;
    logic [3:0]    div_cnt;
    logic          dbit;
    logic          ge;
    logic          pre_sat;
    logic          sat_r;
    logic          close_ok;

    assign last = (cnt == LAST);

    // Acquisition runs regardless of the divider; a strobe on the
    // close cycle already belongs to the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            win_close <= 1'b0;
            max_red   <= '0;
            min_red   <= '0;
            max_ir    <= '0;
            min_ir    <= '0;
        end else if (!enable) begin
            cnt       <= '0;
            win_close <= 1'b0;
        end else begin
            win_close <= sample_en && last;
            if (sample_en) begin
                cnt <= last ? 16'd0 : cnt + 16'd1;
                if (cnt == 16'd0) begin
                    max_red <= filter_red;
                    min_red <= filter_red;
                    max_ir  <= filter_ir;
                    min_ir  <= filter_ir;
                end else begin
                    if (filter_red > max_red) max_red <= filter_red;
                    if (filter_red < min_red) min_red <= filter_red;
                    if (filter_ir > max_ir) max_ir <= filter_ir;
                    if (filter_ir < min_ir) min_ir <= filter_ir;
                end
            end
        end
    end

    assign ac_red_w = max_red - min_red;
    assign ac_ir_w  = max_ir - min_ir;
    assign dc_red_w = DW'(({1'b0, max_red} + {1'b0, min_red}) >> 1);
    assign dc_ir_w  = DW'(({1'b0, max_ir} + {1'b0, min_ir}) >> 1);
    assign num_w    = PW'(ac_red_w) * PW'(dc_ir_w);
    assign den_w    = PW'(ac_ir_w) * PW'(dc_red_w);

    assign close_ok = enable && win_close && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (win_close) next = CALC;
            CALC:    if (div_cnt == 4'hF) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
        if (!enable) next = IDLE;
    end

    // Dividend is num<<8; its top part (num>>8) seeds the remainder so
    // only the low 16 dividend bits need shifting in.
    assign dlo     = {num[7:0], 8'h00};
    assign dbit    = dlo[4'd15 - div_cnt];
    assign rem_in  = (div_cnt == 4'd0) ? RW'(num >> 8) : rem;
    assign trial   = {rem_in[PW-1:0], dbit};
    assign ge      = rem_in[PW] | (trial >= {1'b0, den});
    assign pre_sat = (den == '0) || ({8'h00, num} >= {den, 8'h00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_red      <= '0;
            dc_red      <= '0;
            ac_ir       <= '0;
            dc_ir       <= '0;
            num         <= '0;
            den         <= '0;
            rem         <= '0;
            quot        <= '0;
            div_cnt     <= '0;
            sat_r       <= 1'b0;
            ratio_q88   <= '0;
            ratio_sat   <= 1'b0;
            ratio_valid <= 1'b0;
        end else begin
            ratio_valid <= 1'b0;
            if (close_ok) begin
                ac_red <= ac_red_w;
                dc_red <= dc_red_w;
                ac_ir  <= ac_ir_w;
                dc_ir  <= dc_ir_w;
                num    <= num_w;
                den    <= den_w;
            end
            if (state == CALC && enable) begin
                div_cnt <= div_cnt + 4'd1;
                rem     <= ge ? trial - {1'b0, den} : trial;
                quot    <= {quot[14:0], ge};
                if (div_cnt == 4'd0) sat_r <= pre_sat;
            end else begin
                div_cnt <= '0;
            end
            if (state == DONE && enable) begin
                ratio_q88   <= sat_r ? 16'hFFFF : quot;
                ratio_sat   <= sat_r;
                ratio_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == CALC);

endmodule
